// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the 16-bit processor.
// Holds the instruction register, steps the program counter and issues a
// Moore control word per state to data memory, register file and ALU.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [15:0] ROM_data,
    output logic        PC_clr,
    output logic        PC_up,
    output logic [15:0] IR,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_t state;
    state_t next_state;

    // State register; Clear wins over every transition.
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // Clear is tested inside the clocked block, making the reset synchronous.
    always_ff @(posedge Clock) begin
        if (Clear) state <= S_INIT;
        else       state <= next_state;
    end

    // Instruction register: captures the ROM word on the edge leaving Fetch.
    always_ff @(posedge Clock) begin
        if (Clear)                 IR <= 16'h0000;
        else if (state == S_FETCH) IR <= ROM_data;
    end

    // Next-state logic; Decode dispatches on the already-latched opcode.
    always_comb begin
        next_state = state;
        unique case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    OP_NOOP:  next_state = S_NOOP;
                    OP_STORE: next_state = S_STORE;
                    OP_LOAD:  next_state = S_LOAD_A;
                    OP_ADD:   next_state = S_ADD;
                    OP_SUB:   next_state = S_SUB;
                    OP_HALT:  next_state = S_HALT;
                    default:  next_state = S_NOOP;
                endcase
            end
            S_LOAD_A: next_state = S_LOAD_B;
            S_LOAD_B: next_state = S_FETCH;
            S_NOOP:   next_state = S_FETCH;
            S_STORE:  next_state = S_FETCH;
            S_ADD:    next_state = S_FETCH;
            S_SUB:    next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    // Moore control word decoded from state and IR fields.
    // NOTE: every output gets a zero default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        D_addr     = 8'h00;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'h0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'h0;
        RF_Rb_addr = 4'h0;
        ALU_s0     = 3'd0;
        case (state)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: PC_up  = 1'b1;
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                // Write back only once the synchronous memory read has landed.
                RF_W_en   = (state == S_LOAD_B);
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state == S_ADD) ? 3'd1 : 3'd2;
            end
            default: ;
        endcase
    end

    assign State = state;

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing controller for the 16-bit processor. Holds the instruction register (IR), drives the program counter's Clear/Up inputs, and issues per-state control words to data memory, the register file write-back mux, and the ALU. Sits directly upstream of the program counter. Consumes the instruction-ROM word addressed by the PC's 7-bit output Q.

## Interface
- No parameters; all widths are fixed by the 16-bit ISA.
- Clock  in  1  system clock; all state changes on posedge.
- Clear  in  1  synchronous, active-high reset.
- ROM_data  in  16  instruction word at address PC.Q (combinational ROM read).
- PC_clr  out  1  drives the PC's Clear input.
- PC_up  out  1  drives the PC's Up input.
- IR  out  16  current instruction register contents.
- D_addr  out  8  data-memory address.
- D_wr  out  1  data-memory write enable.
- RF_s  out  1  write-back mux select: 1 = data memory, 0 = ALU.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file read port A address.
- RF_Rb_addr  out  4  register-file read port B address.
- ALU_s0  out  3  ALU function: 0 = pass/none, 1 = add, 2 = subtract.
- State  out  4  current state encoding, for display and debug.

## Operation
- IR format: opcode IR[15:12]; remaining fields are per opcode.
- Opcodes:
  - 0000 NOOP.
  - 0001 STORE: Ra = IR[11:8], D_addr = IR[7:0].
  - 0010 LOAD: D_addr = IR[11:4], Rd = IR[3:0].
  - 0011 ADD: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0].
  - 0100 SUB: same fields as ADD.
  - 0101 HALT.
  - 0110–1111: executed as NOOP.
- State encodings: Init = 0, Fetch = 1, Decode = 2, NoOp = 3, Load_A = 4, Load_B = 5, Store = 6, Add = 7, Sub = 8, Halt = 9.
- Transitions:
  - Init → Fetch.
  - Fetch → Decode.
  - Decode → NoOp / Load_A / Store / Add / Sub / Halt, by opcode.
  - Load_A → Load_B.
  - Load_B, NoOp, Store, Add, Sub → Fetch.
  - Halt → Halt.
- Clear dominates every state and every transition → Init.
- Moore outputs, decoded from state and IR. Any output not listed for a state is 0.
  - Init: PC_clr = 1.
  - Fetch: PC_up = 1. IR loads ROM_data on the edge leaving Fetch.
  - Decode: no asserted outputs.
  - NoOp: no asserted outputs.
  - Load_A: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0].
  - Load_B: Load_A outputs plus RF_W_en = 1. The extra cycle absorbs the synchronous data-memory read.
  - Store: D_addr = IR[7:0], RF_Ra_addr = IR[11:8], D_wr = 1.
  - Add: RF_Ra_addr = IR[11:8], RF_Rb_addr = IR[7:4], RF_W_addr = IR[3:0], ALU_s0 = 1, RF_W_en = 1, RF_s = 0.
  - Sub: same as Add, with ALU_s0 = 2.
  - Halt: no asserted outputs. Holds until Clear.
- IR changes only on the Fetch exit edge and on Clear. It is stable through Decode and Execute.

## Timing
- Reset, at the first posedge with Clear = 1:
  - State = Init (0), IR = 16'h0000.
  - PC_clr = 1; every other output 0.
- Clear deasserted: Init lasts exactly one cycle, so the PC is cleared once.
- Per-instruction cycle counts from Fetch to the next Fetch:
  - NOOP, STORE, ADD, SUB, undefined opcodes: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: never returns to Fetch.
- PC_up is high for exactly one cycle per instruction, in Fetch. The PC increments on the same edge that loads IR, so IR holds the word at the pre-increment address.
- Program wrap: the PC wraps 127 → 0 by itself; this block needs no special handling.
- Clear asserted mid-instruction (including Load_A before Load_B): the next state is Init. D_wr and RF_W_en drop at that edge and no partial write-back occurs after it.
- No glitch requirement beyond synchronous-design rules: outputs settle within the cycle after a state change.

## Test plan
- Reset: hold Clear = 1 for 2 cycles → State = 0, PC_clr = 1, IR = 0. Release → State sequence 1, 2, with PC_up = 1 only in state 1.
- ADD: ROM_data = 16'h3123 at fetch → Decode then Add with RF_Ra_addr = 1, RF_Rb_addr = 2, RF_W_addr = 3, ALU_s0 = 1, RF_W_en = 1 for one cycle, then Fetch. SUB 16'h4123 → identical except ALU_s0 = 2.
- LOAD: 16'h21A5 → Load_A with D_addr = 8'h1A, RF_s = 1, RF_W_en = 0; then Load_B with RF_W_en = 1, RF_W_addr = 5; then Fetch (4 cycles total).
- STORE: 16'h17F0 → Store with D_wr = 1, D_addr = 8'hF0, RF_Ra_addr = 7, RF_W_en = 0.
- HALT and undefined: 16'h5000 → State = 9 held for 10+ cycles with PC_up = 0. Then Clear → Init. Separately, 16'hF123 → NoOp path, no enables asserted.
- Mid-op reset: assert Clear during Load_A of 16'h2010 → next state Init, RF_W_en never asserted, IR = 0.
